fp8_mul_sequencer: RTL and testbench

- Nibble-serial front end that sequences a single fp8mul datapath (1-4-3 format, bias 7) behind a 4-bit ready/valid interface.
- Flow: assembles two 8-bit operands from four input nibbles, registers the product, then streams it back as two output nibbles.
- Optional chain mode reuses the last product as operand A, so running products need only one new operand per step.
- Sits between the chip I/O pins and the multiplier; replaces direct operand-register writes.

---
 rtl/fp8_mul_sequencer.sv | 155 +++++++++++++++
 tb/tb_fp8_mul_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_mul_sequencer.sv
// Purpose: nibble-serial front end for one fp8 (1-4-3, bias 7) multiplier, with an optional running-product chain.
// Latency: MUL follows the 4th input nibble; out_valid rises 2 cycles after it (7 cycles per op, 5 per chained step).
// Backpressure: in_ready is low while multiplying or sending; out_nib holds until out_ready accepts it.
module fp8_mul_sequencer #(
   parameter bit CHAIN_EN = 1'b1,
   parameter int COUNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [3:0]         in_nib,
   output logic               in_ready,
   input  logic               chain,
   output logic               out_valid,
   output logic [3:0]         out_nib,
   output logic               out_last,
   input  logic               out_ready,
   output logic               busy,
   output logic               nan_flag,
   output logic [COUNT_W-1:0] op_count
);

   typedef enum logic [2:0] {
      LD_A_LO = 3'd0,
      LD_A_HI = 3'd1,
      LD_B_LO = 3'd2,
      LD_B_HI = 3'd3,
      MUL     = 3'd4,
      SEND_LO = 3'd5,
      SEND_HI = 3'd6
   } state_t;

   typedef struct packed {
      logic       sign;
      logic [3:0] exp;
      logic [2:0] mant;
   } fp8_t;

   localparam logic [7:0] NAN_CODE = 8'h80;

   state_t      state, state_nxt;
   logic [7:0]  op_a, op_b, result;
   logic        in_xfer, out_xfer, chain_take;

   // Multiplier datapath signals
   fp8_t              fa, fb, prod;
   logic [7:0]        mprod;
   logic signed [6:0] e_pre, e_norm, e_fin;
   logic [3:0]        sig;
   logic              guard, sticky, rnd, p_sign;
   logic [4:0]        sig_r;
   logic [2:0]        mant_fin;

   assign in_xfer    = in_valid & in_ready;
   assign out_xfer   = out_valid & out_ready;
   assign chain_take = chain & CHAIN_EN;

   // State register; reset discards any partially assembled operation
   always_ff @(posedge clk) begin
      if (rst) state <= LD_A_LO;
      else     state <= state_nxt;
   end

   // Next-state: advance one nibble per handshake, MUL always takes exactly one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         LD_A_LO: if (in_xfer)  state_nxt = LD_A_HI;
         LD_A_HI: if (in_xfer)  state_nxt = LD_B_LO;
         LD_B_LO: if (in_xfer)  state_nxt = LD_B_HI;
         LD_B_HI: if (in_xfer)  state_nxt = MUL;
         MUL:                   state_nxt = SEND_LO;
         SEND_LO: if (out_xfer) state_nxt = SEND_HI;
         SEND_HI: if (out_xfer) state_nxt = chain_take ? LD_B_LO : LD_A_LO;
         default:               state_nxt = LD_A_LO;
      endcase
   end

   // Outputs decoded from state only, so in_ready and out_valid can never overlap
   always_comb begin
      in_ready  = (state == LD_A_LO) || (state == LD_A_HI) ||
                  (state == LD_B_LO) || (state == LD_B_HI);
      out_valid = (state == SEND_LO) || (state == SEND_HI);
      out_last  = (state == SEND_HI);
      out_nib   = (state == SEND_HI) ? result[7:4] : result[3:0];
      busy      = (state != LD_A_LO);
   end

   // fp8 product: 4x4 significand multiply, normalise, round-half-even, then saturate/flush
   always_comb begin
      fa     = fp8_t'(op_a);
      fb     = fp8_t'(op_b);
      p_sign = fa.sign ^ fb.sign;
      mprod  = {4'b0000, 1'b1, fa.mant} * {4'b0000, 1'b1, fb.mant};
      e_pre  = $signed({3'b000, fa.exp}) + $signed({3'b000, fb.exp}) - 7'sd7;
      if (mprod[7]) begin
         sig    = mprod[7:4];
         guard  = mprod[3];
         sticky = |mprod[2:0];
         e_norm = e_pre + 7'sd1;
      end else begin
         sig    = mprod[6:3];
         guard  = mprod[2];
         sticky = |mprod[1:0];
         e_norm = e_pre;
      end
      rnd   = guard & (sticky | sig[0]);
      sig_r = {1'b0, sig} + {4'b0000, rnd};
      // Rounding carry out of 1.111 becomes 10.000: bump exponent, mantissa wraps to zero
      if (sig_r[4]) begin
         e_fin    = e_norm + 7'sd1;
         mant_fin = 3'b000;
      end else begin
         e_fin    = e_norm;
         mant_fin = sig_r[2:0];
      end
      // A signed zero would alias the NaN code, so every zero result is +0
      if (op_a == NAN_CODE || op_b == NAN_CODE)
         prod = fp8_t'(NAN_CODE);
      else if (fa.exp == 4'h0 || fb.exp == 4'h0)
         prod = fp8_t'(8'h00);
      else if (e_fin > 7'sd15)
         prod = '{sign: p_sign, exp: 4'hF, mant: 3'h7};
      else if (e_fin < 7'sd1)
         prod = fp8_t'(8'h00);
      else
         prod = '{sign: p_sign, exp: e_fin[3:0], mant: mant_fin};
   end

   // Operand assembly, product capture, op counter and chained operand reuse
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a     <= 8'h00;
         op_b     <= 8'h00;
         result   <= 8'h00;
         nan_flag <= 1'b0;
         op_count <= '0;
      end else begin
         case (state)
            LD_A_LO: if (in_xfer) op_a[3:0] <= in_nib;
            LD_A_HI: if (in_xfer) op_a[7:4] <= in_nib;
            LD_B_LO: if (in_xfer) op_b[3:0] <= in_nib;
            LD_B_HI: if (in_xfer) op_b[7:4] <= in_nib;
            MUL: begin
               result   <= prod;
               nan_flag <= (op_a == NAN_CODE) || (op_b == NAN_CODE);
               op_count <= op_count + COUNT_W'(1);
            end
            SEND_HI: if (out_xfer && chain_take) op_a <= result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp8_mul_sequencer.sv
// Purpose: scoreboard bench for fp8_mul_sequencer, two instances (chain on / 8-bit count, chain off / 2-bit count).
// Latency: expected nibbles queued at issue; monitor compares each accepted output nibble on the falling edge.
// Backpressure: out_ready is held low or randomised to exercise stalls; in_valid pulses while busy must be ignored.
module tb_fp8_mul_sequencer;

   typedef struct {
      logic [3:0] nib;
      logic       last;
      int         cnt;
      logic       nan;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] in_valid_v = '0;
   logic [3:0] in_nib_v [2];
   logic [1:0] in_ready_v;
   logic [1:0] chain_v = '0;
   logic [1:0] out_valid_v;
   logic [3:0] out_nib_v [2];
   logic [1:0] out_last_v;
   logic       out_ready = 1'b1;
   logic [1:0] busy_v;
   logic [1:0] nan_v;
   logic [7:0] op_count0;
   logic [1:0] op_count1;

   exp_t q0[$];
   exp_t q1[$];
   exp_t mon_e;
   logic [7:0] model_a [2];
   int   cnt_m [2];
   int   checks = 0;
   int   errors = 0;
   logic rand_bp = 1'b0;
   logic rand_gap = 1'b0;

   always #5 clk = ~clk;

   fp8_mul_sequencer #(.CHAIN_EN(1'b1), .COUNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_nib(in_nib_v[0]),
      .in_ready(in_ready_v[0]), .chain(chain_v[0]), .out_valid(out_valid_v[0]),
      .out_nib(out_nib_v[0]), .out_last(out_last_v[0]), .out_ready(out_ready),
      .busy(busy_v[0]), .nan_flag(nan_v[0]), .op_count(op_count0));

   fp8_mul_sequencer #(.CHAIN_EN(1'b0), .COUNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_nib(in_nib_v[1]),
      .in_ready(in_ready_v[1]), .chain(chain_v[1]), .out_valid(out_valid_v[1]),
      .out_nib(out_nib_v[1]), .out_last(out_last_v[1]), .out_ready(out_ready),
      .busy(busy_v[1]), .nan_flag(nan_v[1]), .op_count(op_count1));

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Real value of a finite, nonzero code (sign ignored)
   function automatic real fp8_mag(input logic [7:0] c);
      real r;
      int  ex;
      r  = 1.0 + real'(c[2:0]) / 8.0;
      ex = int'(c[6:3]) - 7;
      while (ex > 0) begin r = r * 2.0; ex--; end
      while (ex < 0) begin r = r / 2.0; ex++; end
      return r;
   endfunction

   // Reference: exact real product, rounded half-even to 4 significant bits, then range-limited
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      real  x, frac;
      int   e, m;
      logic s;
      if (a == 8'h80 || b == 8'h80) return 8'h80;
      if (a[6:3] == 4'h0 || b[6:3] == 4'h0) return 8'h00;
      s = a[7] ^ b[7];
      x = fp8_mag(a) * fp8_mag(b);
      e = 0;
      while (x >= 2.0) begin x = x / 2.0; e++; end
      while (x < 1.0) begin x = x * 2.0; e--; end
      x    = x * 8.0;
      m    = $rtoi(x);
      frac = x - real'(m);
      if (frac > 0.5 || (frac == 0.5 && (m % 2) == 1)) m++;
      if (m == 16) begin m = 8; e++; end
      e = e + 7;
      if (e > 15) return {s, 4'hF, 3'h7};
      if (e < 1) return 8'h00;
      return {s, e[3:0], m[2:0]};
   endfunction

   // Monitor: every accepted output nibble must match the head of that instance's queue
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("excl_ready_valid%0d", d), int'(in_ready_v[d] & out_valid_v[d]), 0);
            if (out_valid_v[d] && out_ready) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  chk($sformatf("unexpected_out%0d", d), 1, 0);
               end else begin
                  if (d == 0) mon_e = q0.pop_front();
                  else        mon_e = q1.pop_front();
                  chk($sformatf("out_nib%0d", d), int'(out_nib_v[d]), int'(mon_e.nib));
                  chk($sformatf("out_last%0d", d), int'(out_last_v[d]), int'(mon_e.last));
                  chk($sformatf("op_count%0d", d), (d == 0) ? int'(op_count0) : int'(op_count1), mon_e.cnt);
                  chk($sformatf("nan_flag%0d", d), int'(nan_v[d]), int'(mon_e.nan));
               end
            end
         end
      end
   end

   task automatic reset_dut();
      rst = 1'b1;
      q0.delete();
      q1.delete();
      in_valid_v = '0;
      for (int d = 0; d < 2; d++) begin
         model_a[d] = 8'h00;
         cnt_m[d]   = 0;
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic check_idle(input int d, input string tag);
      chk({tag, "_out_valid"}, int'(out_valid_v[d]), 0);
      chk({tag, "_in_ready"}, int'(in_ready_v[d]), 1);
      chk({tag, "_busy"}, int'(busy_v[d]), 0);
      chk({tag, "_out_last"}, int'(out_last_v[d]), 0);
      chk({tag, "_op_count"}, (d == 0) ? int'(op_count0) : int'(op_count1), 0);
   endtask

   task automatic send_nib(input int d, input logic [3:0] n);
      int k;
      if (rand_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid_v[d] = 1'b1;
      in_nib_v[d]   = n;
      k = 0;
      while (k < 200) begin
         @(negedge clk);
         if (in_ready_v[d]) begin @(posedge clk); #1; break; end
         k++;
      end
      if (k >= 200) chk("in_ready_timeout", 1, 0);
      in_valid_v[d] = 1'b0;
   endtask

   task automatic wait_drain(input int d);
      int n = 0;
      while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
         @(posedge clk); #1;
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (n >= 300) chk("drain_timeout", 1, 0);
      out_ready = 1'b1;
   endtask

   task automatic wait_out_valid(input int d);
      int n = 0;
      while (!out_valid_v[d] && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) chk("out_valid_timeout", 1, 0);
   endtask

   task automatic push_exp(input int d, input logic [7:0] a, input logic [7:0] b,
                           input logic load_a, output logic [7:0] p);
      logic [7:0] ma;
      exp_t e;
      ma       = load_a ? a : model_a[d];
      p        = ref_mul(ma, b);
      cnt_m[d] = (cnt_m[d] + 1) % ((d == 0) ? 256 : 4);
      e.cnt    = cnt_m[d];
      e.nan    = (ma == 8'h80) || (b == 8'h80);
      e.nib    = p[3:0];
      e.last   = 1'b0;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      e.nib    = p[7:4];
      e.last   = 1'b1;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic send_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic load_a);
      if (load_a) begin
         send_nib(d, a[3:0]);
         send_nib(d, a[7:4]);
      end
      send_nib(d, b[3:0]);
      send_nib(d, b[7:4]);
   endtask

   task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic ch, input logic load_a, input logic lat_chk);
      logic [7:0] p;
      push_exp(d, a, b, load_a, p);
      chain_v[d] = ch;
      send_op(d, a, b, load_a);
      if (lat_chk) begin
         chk("mul_out_valid", int'(out_valid_v[d]), 0);
         chk("mul_in_ready", int'(in_ready_v[d]), 0);
         @(posedge clk); #1;
         chk("send_out_valid", int'(out_valid_v[d]), 1);
         chk("send_busy", int'(busy_v[d]), 1);
      end
      wait_drain(d);
      if (ch && d == 0) model_a[d] = p;
      chk($sformatf("post_busy%0d", d), int'(busy_v[d]), (ch && d == 0) ? 1 : 0);
      chk($sformatf("post_in_ready%0d", d), int'(in_ready_v[d]), 1);
      chain_v[d] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] p, a, b;
      logic       chained;
      int         wrap_exp [5] = '{1, 2, 3, 0, 1};
      in_nib_v[0] = 4'h0;
      in_nib_v[1] = 4'h0;
      @(posedge clk); #1;
      reset_dut();
      check_idle(0, "reset");
      chk("reset_nan", int'(nan_v[0]), 0);

      // Directed products, including the sign and NaN paths
      run_op(0, 8'h38, 8'h40, 1'b0, 1'b1, 1'b1);
      run_op(0, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b1);
      run_op(0, 8'hB8, 8'h40, 1'b0, 1'b1, 1'b1);
      run_op(0, 8'h80, 8'h38, 1'b0, 1'b1, 1'b1);

      // Chain: 2*2 then reuse 4.0 as A, only B supplied
      run_op(0, 8'h40, 8'h40, 1'b1, 1'b1, 1'b1);
      run_op(0, 8'h00, 8'h40, 1'b0, 1'b0, 1'b1);

      // Backpressure in SEND_LO with in_valid pulses that must be ignored
      push_exp(0, 8'h38, 8'h40, 1'b1, p);
      out_ready = 1'b0;
      send_op(0, 8'h38, 8'h40, 1'b1);
      wait_out_valid(0);
      for (int i = 0; i < 10; i++) begin
         in_valid_v[0] = 1'($urandom_range(0, 1));
         in_nib_v[0]   = 4'($urandom_range(0, 15));
         @(negedge clk);
         chk("stall_out_valid", int'(out_valid_v[0]), 1);
         chk("stall_out_nib", int'(out_nib_v[0]), int'(p[3:0]));
         chk("stall_in_ready", int'(in_ready_v[0]), 0);
         @(posedge clk); #1;
      end
      in_valid_v[0] = 1'b0;
      out_ready = 1'b1;
      wait_drain(0);
      repeat (2) begin @(posedge clk); #1; end
      chk("after_stall_out_valid", int'(out_valid_v[0]), 0);
      chk("after_stall_busy", int'(busy_v[0]), 0);

      // Reset after three input nibbles
      send_nib(0, 4'h8);
      send_nib(0, 4'h3);
      send_nib(0, 4'h0);
      reset_dut();
      check_idle(0, "rst_midload");

      // Reset while the high nibble is waiting
      push_exp(0, 8'h3C, 8'h40, 1'b1, p);
      out_ready = 1'b0;
      send_op(0, 8'h3C, 8'h40, 1'b1);
      wait_out_valid(0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("send_hi_last", int'(out_last_v[0]), 1);
      reset_dut();
      out_ready = 1'b1;
      check_idle(0, "rst_sendhi");
      run_op(0, 8'h38, 8'h40, 1'b0, 1'b1, 1'b1);

      // Randomised operands, chaining, input gaps and output stalls
      rand_bp  = 1'b1;
      rand_gap = 1'b1;
      chained  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) a = 8'h80;
         if ($urandom_range(0, 7) == 0) b = 8'h80;
         if ($urandom_range(0, 7) == 0) b = 8'h01;
         run_op(0, a, b, 1'($urandom_range(0, 1)), !chained, 1'b0);
         chained = (busy_v[0] == 1'b1);
      end
      if (chained) run_op(0, 8'h00, 8'h38, 1'b0, 1'b0, 1'b0);
      rand_bp  = 1'b0;
      rand_gap = 1'b0;
      out_ready = 1'b1;

      // Chain disabled, 2-bit counter wraps 1,2,3,0,1
      reset_dut();
      check_idle(1, "reset1");
      for (int i = 0; i < 5; i++) begin
         run_op(1, 8'h38, 8'h40, 1'b1, 1'b1, 1'b1);
         chk("wrap_count", int'(op_count1), wrap_exp[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
